// File: rtl/pcs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcs_pkg
// Description : Shared constants and block type for the PCS transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
package pcs_pkg;

    localparam int GB_WORD_W = 32;
    localparam int GB_HDR_W  = 2;
    localparam int GB_FILL_W = 7;

    localparam logic [5:0] GB_SEQ_MAX = 6'd32;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    // Packed MSB-first, so hdr lands at bits [1:0] and is transmitted first.
    typedef struct packed {
        logic [31:0] data_hi;
        logic [31:0] data_lo;
        logic [1:0]  hdr;
    } pcs_block_t;

    localparam int GB_BLOCK_W = $bits(pcs_block_t);

endpackage
`default_nettype wire

// File: rtl/pcs_gearbox_acc.sv
`default_nettype none
// ============================================================================
// Module      : pcs_gearbox_acc
// Description : 66-bit append/pop shift accumulator feeding the 32-bit output.
// Revision    : 1.0 - initial release
// ============================================================================
module pcs_gearbox_acc
    import pcs_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_flush,
    input  logic                 i_push,
    input  logic                 i_push_hdr,
    input  logic [GB_WORD_W-1:0] i_data,
    input  logic [GB_HDR_W-1:0]  i_hdr,
    output logic [GB_WORD_W-1:0] o_data,
    output logic                 o_valid
);

    localparam logic [GB_FILL_W-1:0] c_WORD_BITS     = 7'd32;
    localparam logic [GB_FILL_W-1:0] c_HDR_WORD_BITS = 7'd34;
    localparam logic [GB_FILL_W-1:0] c_BLOCK_BITS    = 7'd66;

    logic [GB_BLOCK_W-1:0] r_buf;
    logic [GB_FILL_W-1:0]  r_fill;
    logic [GB_WORD_W-1:0]  r_data;
    logic                  r_valid;

    logic [GB_BLOCK_W-1:0] w_ins;
    logic [GB_BLOCK_W-1:0] w_comb;
    logic [GB_BLOCK_W-1:0] w_buf_nxt;
    logic [GB_FILL_W-1:0]  w_push_len;
    logic [GB_FILL_W-1:0]  w_sum;
    logic [GB_FILL_W-1:0]  w_fill_nxt;
    logic                  w_pop;

    // Bits above r_fill are always zero, so appending is a plain OR.
    always_comb begin
        w_ins      = '0;
        w_push_len = '0;
        if (i_push) begin
            if (i_push_hdr) begin
                w_ins      = GB_BLOCK_W'({i_data, i_hdr});
                w_push_len = c_HDR_WORD_BITS;
            end else begin
                w_ins      = GB_BLOCK_W'(i_data);
                w_push_len = c_WORD_BITS;
            end
        end
        w_comb     = r_buf | (w_ins << r_fill);
        w_sum      = r_fill + w_push_len;
        w_pop      = (w_sum >= c_WORD_BITS);
        w_buf_nxt  = w_pop ? (w_comb >> c_WORD_BITS) : w_comb;
        w_fill_nxt = w_pop ? (w_sum - c_WORD_BITS) : w_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf   <= '0;
            r_fill  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_buf   <= '0;
            r_fill  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_buf   <= w_buf_nxt;
            r_fill  <= w_fill_nxt;
            r_valid <= w_pop;
            if (w_pop) begin
                r_data <= w_comb[GB_WORD_W-1:0];
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) w_sum <= c_BLOCK_BITS);

endmodule
`default_nettype wire

// File: rtl/pcs_tx_gearbox.sv
`default_nettype none
// ============================================================================
// Module      : pcs_tx_gearbox
// Description : 66b->32b TX gearbox; owns sequence, pause and error/resync.
// Revision    : 1.0 - initial release
// ============================================================================
module pcs_tx_gearbox
    import pcs_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int HDR_WIDTH  = 2
) (
    input  logic                  gty_tx_usr_clk,
    input  logic                  gty_tx_usr_reset,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic [HDR_WIDTH-1:0]  i_tx_hdr,
    input  logic                  i_tx_hdr_valid,
    input  logic                  i_tx_valid,
    output logic                  o_tx_pause,
    output logic [DATA_WIDTH-1:0] o_gearbox_data,
    output logic                  o_gearbox_valid,
    input  logic                  i_err_clr,
    output logic                  o_err
);

    generate
        if (DATA_WIDTH != GB_WORD_W || HDR_WIDTH != GB_HDR_W) begin : g_bad_width
            $error("pcs_tx_gearbox supports only DATA_WIDTH=32 and HDR_WIDTH=2");
        end
    endgenerate

    logic [5:0] r_seq;
    logic       r_err;

    logic w_pause;
    logic w_expect_hdr;
    logic w_err;
    logic w_push;

    assign w_pause      = (r_seq == GB_SEQ_MAX);
    assign w_expect_hdr = ~r_seq[0];
    // Input is ignored entirely during the pause slot.
    assign w_err        = ~w_pause & (~i_tx_valid | (i_tx_hdr_valid != w_expect_hdr));
    assign w_push       = ~w_pause & ~w_err;

    always_ff @(posedge gty_tx_usr_clk or negedge gty_tx_usr_reset) begin
        if (!gty_tx_usr_reset) begin
            r_seq <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_err || w_pause) begin
                r_seq <= '0;
            end else begin
                r_seq <= r_seq + 6'd1;
            end
            if (w_err) begin
                r_err <= 1'b1;
            end else if (i_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    pcs_gearbox_acc u_acc (
        .clk        (gty_tx_usr_clk),
        .rst_n      (gty_tx_usr_reset),
        .i_flush    (w_err),
        .i_push     (w_push),
        .i_push_hdr (w_expect_hdr),
        .i_data     (i_tx_data),
        .i_hdr      (i_tx_hdr),
        .o_data     (o_gearbox_data),
        .o_valid    (o_gearbox_valid)
    );

    assign o_tx_pause = w_pause;
    assign o_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pcs_tx_gearbox.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcs_tx_gearbox
// Description : Self-checking bench with a bit-queue reference of the gearbox.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcs_tx_gearbox;
    import pcs_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] tx_data = '0;
    logic [1:0]  tx_hdr = '0;
    logic        tx_hdr_valid = 1'b0;
    logic        tx_valid = 1'b0;
    logic        err_clr = 1'b0;
    logic        o_tx_pause;
    logic [31:0] o_gearbox_data;
    logic        o_gearbox_valid;
    logic        o_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pcs_tx_gearbox #(.DATA_WIDTH(32), .HDR_WIDTH(2)) dut (
        .gty_tx_usr_clk   (clk),
        .gty_tx_usr_reset (rst_n),
        .i_tx_data        (tx_data),
        .i_tx_hdr         (tx_hdr),
        .i_tx_hdr_valid   (tx_hdr_valid),
        .i_tx_valid       (tx_valid),
        .o_tx_pause       (o_tx_pause),
        .o_gearbox_data   (o_gearbox_data),
        .o_gearbox_valid  (o_gearbox_valid),
        .i_err_clr        (err_clr),
        .o_err            (o_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the transmitted line is a plain bit queue; each output word
    // is the next 32 bits of it. Position counts cycles since the last sync.
    bit          mq[$];
    int          m_pos;
    logic        e_valid;
    logic        e_err;
    logic [31:0] e_data;
    wire         e_pause = (m_pos == 32);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pos   = 0;
            e_valid = 1'b0;
            e_err   = 1'b0;
            e_data  = '0;
        end else begin : model_step
            bit in_pause;
            bit bad;
            in_pause = (m_pos == 32);
            bad = !in_pause && (!tx_valid || (tx_hdr_valid != ((m_pos % 2) == 0)));
            if (bad) begin
                mq.delete();
                m_pos   = 0;
                e_valid = 1'b0;
                e_err   = 1'b1;
            end else begin
                if (!in_pause) begin
                    if ((m_pos % 2) == 0)
                        for (int i = 0; i < 2; i++) mq.push_back(tx_hdr[i]);
                    for (int i = 0; i < 32; i++) mq.push_back(tx_data[i]);
                end
                if (mq.size() >= 32) begin
                    for (int i = 0; i < 32; i++) e_data[i] = mq.pop_front();
                    e_valid = 1'b1;
                end else begin
                    e_valid = 1'b0;
                end
                if (err_clr) e_err = 1'b0;
                m_pos = in_pause ? 0 : m_pos + 1;
            end
        end
    end

    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc = 0;
        else        cyc = cyc + 1;
    end

    bit pause_seen;
    int pause_cyc;
    always @(negedge clk) begin
        if (!rst_n) begin
            pause_seen = 1'b0;
            pause_cyc  = -1;
        end else begin
            if (o_tx_pause && !pause_seen) begin
                pause_seen = 1'b1;
                pause_cyc  = cyc;
            end
            chk("pause", 32'(o_tx_pause), 32'(e_pause));
            chk("valid", 32'(o_gearbox_valid), 32'(e_valid));
            chk("err", 32'(o_err), 32'(e_err));
            chk("fill", 32'(dut.u_acc.r_fill), 32'(mq.size()));
            if (e_valid) chk("data", o_gearbox_data, e_data);
        end
    end

    task automatic drive(input logic v, input logic hv, input logic [31:0] d,
                         input logic [1:0] h, input logic clr);
        tx_valid     = v;
        tx_hdr_valid = hv;
        tx_data      = d;
        tx_hdr       = h;
        err_clr      = clr;
        @(posedge clk);
        #1;
    endtask

    // Upstream holds the pending word through the pause slot.
    task automatic send_word(input logic hv, input logic [31:0] d, input logic [1:0] h,
                             input logic clr);
        if (e_pause) drive(1'b1, hv, d, h, clr);
        drive(1'b1, hv, d, h, clr);
    endtask

    task automatic send_block(input logic [1:0] h, input logic [31:0] lo, input logic [31:0] hi);
        send_word(1'b1, lo, h, 1'b0);
        send_word(1'b0, hi, 2'b00, 1'b0);
    endtask

    task automatic send_next(input logic clr);
        send_word(((m_pos % 2) == 0), $urandom, ($urandom_range(0, 1) != 0) ? HDR_DATA : HDR_CTRL, clr);
    endtask

    function automatic logic [31:0] inc_word(input int b, input int off);
        return {8'(8 * b + off + 3), 8'(8 * b + off + 2), 8'(8 * b + off + 1), 8'(8 * b + off)};
    endfunction

    initial begin
        // Reset values
        #12;
        chk("rst_data", o_gearbox_data, 32'h0);
        chk("rst_valid", 32'(o_gearbox_valid), 32'h0);
        chk("rst_pause", 32'(o_tx_pause), 32'h0);
        chk("rst_err", 32'(o_err), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First block, hand-computed output words
        send_word(1'b1, 32'h03020100, HDR_DATA, 1'b0);
        chk("blk0_word0", o_gearbox_data, 32'h0C080401);
        chk("blk0_valid0", 32'(o_gearbox_valid), 32'h1);
        send_word(1'b0, 32'h07060504, 2'b00, 1'b0);
        chk("blk0_word1", o_gearbox_data, 32'h1C181410);

        // Remaining 15 incrementing blocks, then one word across the pause
        for (int b = 1; b < 16; b++) send_block(HDR_DATA, inc_word(b, 0), inc_word(b, 4));
        chk("pre_pause_seq31", 32'(o_tx_pause), 32'h1);
        send_next(1'b0);
        chk("first_pause_cycle", 32'(pause_cyc), 32'd32);
        chk("post_pause_valid", 32'(o_gearbox_valid), 32'h1);
        send_word(1'b0, $urandom, 2'b00, 1'b0);

        // Continuous random blocks honouring the pause
        for (int b = 0; b < 470; b++)
            send_block(($urandom_range(0, 1) != 0) ? HDR_DATA : HDR_CTRL, $urandom, $urandom);
        chk("random_no_err", 32'(o_err), 32'h0);

        // Underflow at seq 7
        for (int k = 0; k < 40 && m_pos != 7; k++) send_next(1'b0);
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
        chk("uflow_err", 32'(o_err), 32'h1);
        chk("uflow_valid", 32'(o_gearbox_valid), 32'h0);
        chk("uflow_seq", 32'(dut.r_seq), 32'h0);
        send_next(1'b0);
        chk("resync_valid", 32'(o_gearbox_valid), 32'h1);
        send_next(1'b1);
        chk("clr_err", 32'(o_err), 32'h0);

        // Header flag at an odd position
        send_next(1'b0);
        drive(1'b1, 1'b1, 32'hDEADBEEF, HDR_DATA, 1'b0);
        chk("phase_err", 32'(o_err), 32'h1);
        chk("phase_valid", 32'(o_gearbox_valid), 32'h0);
        chk("phase_seq", 32'(dut.r_seq), 32'h0);
        drive(1'b1, 1'b0, 32'h12345678, 2'b00, 1'b1);
        chk("clr_vs_set", 32'(o_err), 32'h1);
        send_next(1'b1);
        chk("clr_after", 32'(o_err), 32'h0);
        chk("clr_after_valid", 32'(o_gearbox_valid), 32'h1);

        // Asynchronous reset mid-block at seq 19
        for (int k = 0; k < 40 && m_pos != 19; k++) send_next(1'b0);
        chk("pre_rst_seq", 32'(dut.r_seq), 32'd19);
        rst_n = 1'b0;
        #1;
        chk("arst_data", o_gearbox_data, 32'h0);
        chk("arst_valid", 32'(o_gearbox_valid), 32'h0);
        chk("arst_pause", 32'(o_tx_pause), 32'h0);
        chk("arst_err", 32'(o_err), 32'h0);
        chk("arst_fill", 32'(dut.u_acc.r_fill), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int b = 0; b < 16; b++) send_block(HDR_CTRL, inc_word(b, 64), inc_word(b, 68));
        send_next(1'b0);
        chk("rst_first_pause", 32'(pause_cyc), 32'd32);
        send_next(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
